aixh_mxc_upper_rowctl: RTL
==========================

// Module: aixh_mxc_upper_rowctl
// PURPOSE
//  Left-edge controller of one MxConv upper processing-tile row. Drives the row's horizontal
//  UPCELL forward command chain and terminates the backward UPCELL data chain that returns
//  through cell 0. Converts a valid/ready job request into one chain command, counts the
//  returned per-cell beats into a credit-protected FIFO, and presents them as a valid/ready stream.
// PARAMETERS
//  NUM_TILES   4                          processing tiles in the row; NCELLS = NUM_TILES*IPTILE_XCELLS
//  FIFO_DEPTH  2*NUM_TILES*IPTILE_XCELLS  response FIFO entries; must be >= NCELLS (elaboration error otherwise)
//  TMO_CYCLES  1024                       max cycles in WAIT before timeout abort
// PORTS
//  aixh_core_clk2x  in   1                    sole clock
//  aixh_core_rst2x  in   1                    reset, asynchronous, active-high
//  i_req_vld        in   1                    job request valid
//  o_req_rdy        out  1                    job request ready
//  i_req_op         in   UPC_OP_W             command opcode (UPC_OP_* from package)
//  i_req_arg        in   UPC_ARG_W            command argument
//  i_req_rsp        in   1                    1: command returns NCELLS backward beats
//  o_upt_cmd        out  UPCELL_FWD_CWIDTH    forward chain command (upc_cmd_t), into cell 0
//  i_upt_vld        in   1                    backward chain beat valid, from cell 0
//  i_upt_dat        in   UPCELL_BWD_DWIDTH    backward chain beat data
//  o_rsp_vld        out  1                    response stream valid
//  i_rsp_rdy        in   1                    response stream ready
//  o_rsp_dat        out  UPCELL_BWD_DWIDTH    response data
//  o_rsp_idx        out  $clog2(NCELLS)       source cell index of beat (0 = first returned)
//  o_rsp_last       out  1                    last beat of a response (idx == NCELLS-1)
//  o_busy           out  1                    state != IDLE or FIFO non-empty
//  o_err_tmo        out  1                    sticky: WAIT timed out
//  o_err_unx        out  1                    sticky: beat outside WAIT, or beat with FIFO full (beat dropped)
//  i_err_clr        in   1                    clears both sticky errors (set wins if same cycle)
// BEHAVIOUR
//  Reset: state IDLE; o_upt_cmd='0 (NOP, vld field 0); o_rsp_vld=0; o_rsp_idx=0; o_rsp_last=0;
//   o_busy=0; errors 0; FIFO empty; beat counter 0; timeout counter 0. Reset mid-job discards all.
//  o_req_rdy = (state==IDLE) && (fifo_free >= NCELLS); independent of i_req_vld/i_req_rsp.
//  FSM: IDLE --accept--> ISSUE; ISSUE --rsp=0--> IDLE; ISSUE --rsp=1--> WAIT;
//   WAIT --beat count reaches NCELLS--> IDLE; WAIT --tmo counter == TMO_CYCLES-1--> IDLE, set o_err_tmo.
//  Command: accepted at cycle t -> o_upt_cmd = {vld=1, op, arg} registered, valid exactly cycle t+1
//   (ISSUE); '0 every other cycle. Minimum spacing between commands: 2 cycles.
//  Beats: every i_upt_vld in WAIT writes {dat, idx=cnt, last=(cnt==NCELLS-1)} into FIFO; cnt++.
//   No backpressure on chain; credit check at accept guarantees space. Beats may have gaps.
//  Timeout counter clears on entry to WAIT and on each beat; abort leaves written beats in FIFO
//   (no o_rsp_last for that job), counter reset to 0.
//  Beat in IDLE/ISSUE, or with FIFO full: dropped, o_err_unx set next cycle.
//  Beat on same cycle as timeout expiry: beat accepted, timeout takes precedence for state.
//  FIFO: first-word-fall-through latency 1 (beat at t -> o_rsp_vld at t+1 if empty); pop on
//   o_rsp_vld&&i_rsp_rdy; simultaneous push/pop when full is NOT allowed (push drops); when
//   empty, push/pop same cycle only pops older data (none) -> push visible next cycle.
//  Pointers wrap modulo FIFO_DEPTH; full/empty via extra wrap bit; fifo_free = DEPTH - count.
// STRUCTURE
//  AIXH_MXC_pkg: upc_cmd_t (vld, op, arg packed to UPCELL_FWD_CWIDTH), UPC_OP_W, UPC_ARG_W,
//   UPC_OP_* opcodes, UPC_CMD_NOP='0.
//  One sub-module: aixh_mxc_upper_rspfifo (sync FWFT FIFO, width DWIDTH+idx+1, count output).
//  FSM, credit check, beat/timeout counters, error flags in this module.
// TESTING
//  1 reset mid-WAIT with 3 beats in FIFO -> all outputs at reset values, o_req_rdy=1 next cycle.
//  2 NUM_TILES=4,XCELLS=4: req rsp=1 op=2 at t -> o_upt_cmd vld at t+1 only; 16 beats (gaps) ->
//    16 rsp beats idx 0..15, last only on 15, data in order; FIFO returns to IDLE/o_busy=0.
//  3 rsp=0 commands back-to-back with i_req_vld held -> cmd every 2nd cycle, no FIFO writes.
//  4 FIFO_DEPTH=24, i_rsp_rdy=0 after one 16-beat job -> o_req_rdy=0 (free 8<16); pop 8 -> rdy=1.
//  5 rsp=1, 5 beats then silence, TMO_CYCLES=32 -> IDLE 32 cycles after last beat, o_err_tmo=1,
//    5 beats readable without last; i_err_clr -> o_err_tmo=0.
//  6 i_upt_vld in IDLE -> beat dropped, o_err_unx=1, o_rsp_vld stays 0.

Source files
------------

// File: rtl/aixh_mxc_upper_rowctl_pkg.sv
// ---------------------------------------------------------------------------
// aixh_mxc_upper_rowctl_pkg
//   Shared definitions for the MxConv upper-row UPCELL chains:
//   - chain widths and geometry constants
//   - forward command format (upc_cmd_t) and opcodes
//   - row-controller FSM state encoding (exported on the debug port)
// ---------------------------------------------------------------------------
package aixh_mxc_upper_rowctl_pkg;

  // Geometry: cells per processing tile along the row
  localparam int IPTILE_XCELLS = 4;

  // Forward command chain fields
  localparam int UPC_OP_W          = 4;
  localparam int UPC_ARG_W         = 16;
  localparam int UPCELL_FWD_CWIDTH = 1 + UPC_OP_W + UPC_ARG_W;

  // Backward data chain beat width
  localparam int UPCELL_BWD_DWIDTH = 16;

  // Opcodes
  localparam logic [UPC_OP_W-1:0] UPC_OP_NOP   = 4'd0;
  localparam logic [UPC_OP_W-1:0] UPC_OP_LDW   = 4'd1;
  localparam logic [UPC_OP_W-1:0] UPC_OP_CONV  = 4'd2;
  localparam logic [UPC_OP_W-1:0] UPC_OP_RDACC = 4'd3;
  localparam logic [UPC_OP_W-1:0] UPC_OP_CLR   = 4'd4;

  // Forward chain command; vld=0 means the chain sees a NOP
  typedef struct packed {
    logic                 vld;
    logic [UPC_OP_W-1:0]  op;
    logic [UPC_ARG_W-1:0] arg;
  } upc_cmd_t;

  localparam upc_cmd_t UPC_CMD_NOP = '0;

  // Row controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } rowctl_state_t;

  function automatic upc_cmd_t upc_cmd_make(input logic [UPC_OP_W-1:0]  op,
                                            input logic [UPC_ARG_W-1:0] arg);
    upc_cmd_t c;
    c.vld = 1'b1;
    c.op  = op;
    c.arg = arg;
    return c;
  endfunction

endpackage

// File: rtl/aixh_mxc_upper_rspfifo.sv
// ---------------------------------------------------------------------------
// aixh_mxc_upper_rspfifo
//   Synchronous first-word-fall-through FIFO for returned row beats.
//   A push at cycle t is visible on out_vld/out_dat at t+1 when empty.
//   Push while full is dropped (even with a simultaneous pop); pop while
//   empty is ignored. DEPTH need not be a power of two: indices wrap at
//   DEPTH-1 and a wrap bit per pointer distinguishes full from empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push/push_dat write request and data
//   pop           read acknowledge (head removed when out_vld)
//   out_vld/out_dat head entry
//   count         number of stored entries (0..DEPTH)
//   full/empty    status
// ---------------------------------------------------------------------------
module aixh_mxc_upper_rspfifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             wr_wrap, rd_wrap;
  logic             do_push, do_pop;

  assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign out_vld = !empty;
  assign out_dat = mem[rd_idx];

  // Occupancy from index distance; the wrap bits tell whether the writer
  // has lapped the reader.
  always_comb begin
    count = '0;
    if (wr_wrap == rd_wrap) count = CW'(wr_idx) - CW'(rd_idx);
    else                    count = CW'(DEPTH) - CW'(rd_idx) + CW'(wr_idx);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_wrap <= 1'b0;
      rd_idx  <= '0;
      rd_wrap <= 1'b0;
    end else begin
      if (do_push) begin
        if (wr_idx == AW'(DEPTH - 1)) begin
          wr_idx  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_idx <= wr_idx + AW'(1);
        end
      end
      if (do_pop) begin
        if (rd_idx == AW'(DEPTH - 1)) begin
          rd_idx  <= '0;
          rd_wrap <= ~rd_wrap;
        end else begin
          rd_idx <= rd_idx + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/aixh_mxc_upper_rowctl.sv
// ---------------------------------------------------------------------------
// aixh_mxc_upper_rowctl
//   Left-edge controller of one MxConv upper processing-tile row.
//   Turns an accepted job request into a single one-cycle forward chain
//   command, then (for response jobs) collects NCELLS backward beats from
//   cell 0 into a credit-protected FWFT FIFO and streams them out.
//
// Handshakes (all valid/ready): a transfer happens on a rising clock edge
//   where valid and ready are both 1. Ready never depends on valid. Once
//   valid is raised by a producer it is held with stable payload until the
//   transfer. The backward chain (i_upt_vld) has no ready: every beat in
//   WAIT is taken; space is guaranteed by requiring NCELLS free entries
//   before a job is accepted.
//
// Ports:
//   aixh_core_clk2x / aixh_core_rst2x   clock, async active-high reset
//   i_req_vld/o_req_rdy, i_req_op/arg/rsp   job request
//   o_upt_cmd                            forward chain command into cell 0
//   i_upt_vld/i_upt_dat                  backward chain beat from cell 0
//   o_rsp_vld/i_rsp_rdy, o_rsp_dat/idx/last  response stream
//   o_busy                               FSM active or FIFO non-empty
//   o_err_tmo/o_err_unx, i_err_clr       sticky error flags and clear
//   o_dbg_state                          current FSM state (rowctl_state_t)
// ---------------------------------------------------------------------------
module aixh_mxc_upper_rowctl
  import aixh_mxc_upper_rowctl_pkg::*;
#(
  parameter int NUM_TILES  = 4,
  parameter int FIFO_DEPTH = 2 * NUM_TILES * IPTILE_XCELLS,
  parameter int TMO_CYCLES = 1024,
  localparam int NCELLS    = NUM_TILES * IPTILE_XCELLS,
  localparam int IW        = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
  input  logic                         aixh_core_clk2x,
  input  logic                         aixh_core_rst2x,
  input  logic                         i_req_vld,
  output logic                         o_req_rdy,
  input  logic [UPC_OP_W-1:0]          i_req_op,
  input  logic [UPC_ARG_W-1:0]         i_req_arg,
  input  logic                         i_req_rsp,
  output logic [UPCELL_FWD_CWIDTH-1:0] o_upt_cmd,
  input  logic                         i_upt_vld,
  input  logic [UPCELL_BWD_DWIDTH-1:0] i_upt_dat,
  output logic                         o_rsp_vld,
  input  logic                         i_rsp_rdy,
  output logic [UPCELL_BWD_DWIDTH-1:0] o_rsp_dat,
  output logic [IW-1:0]                o_rsp_idx,
  output logic                         o_rsp_last,
  output logic                         o_busy,
  output logic                         o_err_tmo,
  output logic                         o_err_unx,
  input  logic                         i_err_clr,
  output logic [1:0]                   o_dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam int RW = UPCELL_BWD_DWIDTH + IW + 1;

  generate
    if (FIFO_DEPTH < NCELLS) begin : g_bad_depth
      $error("aixh_mxc_upper_rowctl: FIFO_DEPTH must be >= NCELLS");
    end
    if (TMO_CYCLES < 2) begin : g_bad_tmo
      $error("aixh_mxc_upper_rowctl: TMO_CYCLES must be >= 2");
    end
  endgenerate

  rowctl_state_t state, state_nxt;
  upc_cmd_t      cmd_q;
  logic          rsp_q;
  logic [IW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic          err_tmo_q, err_unx_q;

  logic          accept;
  logic          beat_wait, beat_push, beat_unx, beat_last, tmo_hit;

  logic [RW-1:0] fifo_wdat, fifo_rdat;
  logic          fifo_vld, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, fifo_free;

  // Credit check: a new job may only start when the whole row's worth of
  // beats is guaranteed to fit.
  assign fifo_free = CW'(FIFO_DEPTH) - fifo_count;
  assign o_req_rdy = (state == ST_IDLE) && (fifo_free >= CW'(NCELLS));
  assign accept    = i_req_vld && o_req_rdy;

  // FSM next state and beat classification
  always_comb begin
    state_nxt = state;
    beat_wait = (state == ST_WAIT) && i_upt_vld;
    beat_push = beat_wait && !fifo_full;
    beat_unx  = i_upt_vld && ((state != ST_WAIT) || fifo_full);
    beat_last = (cnt_q == IW'(NCELLS - 1));
    tmo_hit   = (state == ST_WAIT) && (tmo_q == TW'(TMO_CYCLES - 1));
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = rsp_q ? ST_WAIT : ST_IDLE;
      // Timeout wins over completion when both land in the same cycle
      ST_WAIT: begin
        if (tmo_hit)                      state_nxt = ST_IDLE;
        else if (beat_wait && beat_last)  state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
    if (aixh_core_rst2x) begin
      state     <= ST_IDLE;
      cmd_q     <= UPC_CMD_NOP;
      rsp_q     <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
      err_unx_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Command is live for exactly the ISSUE cycle
      cmd_q <= accept ? upc_cmd_make(i_req_op, i_req_arg) : UPC_CMD_NOP;
      if (accept) rsp_q <= i_req_rsp;

      // Beat index restarts whenever WAIT is left (completion or abort)
      if (state_nxt != ST_WAIT) cnt_q <= '0;
      else if (beat_wait)       cnt_q <= cnt_q + IW'(1);

      // Silence counter: cleared on WAIT entry, on every beat, and on exit
      if ((state != ST_WAIT) || (state_nxt != ST_WAIT) || beat_wait) tmo_q <= '0;
      else                                                           tmo_q <= tmo_q + TW'(1);

      if (tmo_hit)        err_tmo_q <= 1'b1;
      else if (i_err_clr) err_tmo_q <= 1'b0;

      if (beat_unx)       err_unx_q <= 1'b1;
      else if (i_err_clr) err_unx_q <= 1'b0;
    end
  end

  assign fifo_wdat = {i_upt_dat, cnt_q, beat_last};

  aixh_mxc_upper_rspfifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_rspfifo (
    .clk      (aixh_core_clk2x),
    .rst      (aixh_core_rst2x),
    .push     (beat_push),
    .push_dat (fifo_wdat),
    .pop      (i_rsp_rdy),
    .out_vld  (fifo_vld),
    .out_dat  (fifo_rdat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Storage is not reset, so the payload is forced to zero while empty
  logic [RW-1:0] rsp_word;
  assign rsp_word = fifo_vld ? fifo_rdat : '0;

  assign o_rsp_vld   = fifo_vld;
  assign o_rsp_dat   = rsp_word[RW-1 -: UPCELL_BWD_DWIDTH];
  assign o_rsp_idx   = rsp_word[IW:1];
  assign o_rsp_last  = rsp_word[0];
  assign o_upt_cmd   = cmd_q;
  assign o_busy      = (state != ST_IDLE) || !fifo_empty;
  assign o_err_tmo   = err_tmo_q;
  assign o_err_unx   = err_unx_q;
  assign o_dbg_state = state;

endmodule
